// File: rtl/spi_reg_bank.sv
// ============================================================================
// Module   : spi_reg_bank
// Brief    : SPI-write register bank with staged writes committed on a frame
//            strobe; optional SPI readback enabled by SPI_REG_READBACK_EN.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module spi_reg_bank #(
  parameter int NUM_REGS    = 8,
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALUES = '0
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_sclk,
  input  logic                       i_csb,
  input  logic                       i_mosi,
  input  logic                       i_commit,
  output logic [NUM_REGS*DATA_W-1:0] o_regs,
  output logic                       o_pending,
  output logic                       o_commit_done,
  output logic                       o_err,
  output logic                       o_busy,
  output logic                       o_miso,
  output logic                       o_miso_oeb
);

  localparam int c_L     = ADDR_W + DATA_W;
  localparam int c_CNT_W = $clog2(c_L + 2);
`ifdef SPI_REG_READBACK_EN
  localparam int c_IDX_W = ADDR_W - 1;
`else
  localparam int c_IDX_W = ADDR_W;
`endif
  localparam logic [c_CNT_W-1:0] c_LEN = c_CNT_W'(c_L);
  localparam logic [c_CNT_W-1:0] c_OVF = c_CNT_W'(c_L + 1);
  localparam logic [c_IDX_W:0]   c_NUM = (c_IDX_W + 1)'(NUM_REGS);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SHIFT     = 2'd1,
    S_WAIT_HIGH = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_csb_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_prev;
  logic                   w_sclk_s;
  logic                   w_csb_s;
  logic                   w_mosi_s;
  logic                   w_sclk_rise;

  state_t                 r_state;
  logic [c_CNT_W-1:0]     r_count;
  logic [c_L-1:0]         r_shift;
  logic                   r_ovf;
  logic                   r_err;

  logic [NUM_REGS*DATA_W-1:0] r_regs;
  logic [c_IDX_W-1:0]     r_stage_addr;
  logic [DATA_W-1:0]      r_stage_data;
  logic                   r_pending;
  logic                   r_commit_done;

  logic [ADDR_W-1:0]      w_cmd;
  logic [c_IDX_W-1:0]     w_idx;
  logic [DATA_W-1:0]      w_data;
  logic                   w_is_read;
  logic                   w_addr_ok;
  logic                   w_len_ok;
  logic                   w_frame_end;
  logic                   w_stage;
  logic                   w_bad;
  logic                   w_commit;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_csb_s     = r_csb_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sclk_sync <= '0;
      r_csb_sync  <= '0;
      r_mosi_sync <= '0;
      r_sclk_prev <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_csb_sync  <= {r_csb_sync[SYNC_STAGES-2:0], i_csb};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_sclk_prev <= w_sclk_s;
    end
  end

  assign w_cmd  = r_shift[c_L-1 -: ADDR_W];
  assign w_idx  = w_cmd[c_IDX_W-1:0];
  assign w_data = r_shift[DATA_W-1:0];
`ifdef SPI_REG_READBACK_EN
  assign w_is_read = w_cmd[ADDR_W-1];
`else
  assign w_is_read = 1'b0;
`endif
  assign w_addr_ok   = ({1'b0, w_idx} < c_NUM);
  assign w_len_ok    = (r_count == c_LEN);
  assign w_frame_end = (r_state == S_SHIFT) && w_csb_s;
  assign w_stage     = w_frame_end && w_len_ok && w_addr_ok && !w_is_read;
  assign w_bad       = w_frame_end && (r_count != '0) && !(w_len_ok && w_addr_ok);
  assign w_commit    = i_commit && r_pending;

  // Reset lands in WAIT_HIGH: the cleared csb synchroniser reads as "low",
  // so a frame interrupted by reset is swallowed until csb really rises.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_WAIT_HIGH;
      r_count <= '0;
      r_shift <= '0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_csb_s) begin
            r_state <= S_SHIFT;
            r_count <= '0;
            r_shift <= '0;
          end
        end
        S_SHIFT: begin
          if (w_csb_s) begin
            r_state <= S_IDLE;
            r_err   <= w_bad;
          end else if (w_sclk_rise) begin
            if (r_count == c_LEN) begin
              r_count <= c_OVF;
              r_ovf   <= 1'b1;
              r_state <= S_WAIT_HIGH;
            end else begin
              r_count <= r_count + 1'b1;
              r_shift <= {r_shift[c_L-2:0], w_mosi_s};
            end
          end
        end
        S_WAIT_HIGH: begin
          if (w_csb_s) begin
            r_state <= S_IDLE;
            r_err   <= r_ovf;
            r_ovf   <= 1'b0;
          end
        end
        default: r_state <= S_WAIT_HIGH;
      endcase
    end
  end

  // Commit uses the staging contents from before this edge, so a frame that
  // ends in the commit cycle is staged behind the value being committed.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_regs        <= RESET_VALUES;
      r_stage_addr  <= '0;
      r_stage_data  <= '0;
      r_pending     <= 1'b0;
      r_commit_done <= 1'b0;
    end else begin
      r_commit_done <= w_commit;
      if (w_commit) begin
        r_regs[int'(r_stage_addr)*DATA_W +: DATA_W] <= r_stage_data;
      end
      if (w_stage) begin
        r_stage_addr <= w_idx;
        r_stage_data <= w_data;
        r_pending    <= 1'b1;
      end else if (w_commit) begin
        r_pending <= 1'b0;
      end
    end
  end

`ifdef SPI_REG_READBACK_EN
  localparam logic [c_CNT_W-1:0] c_HDR = c_CNT_W'(ADDR_W);

  logic                   w_sclk_fall;
  logic [ADDR_W-1:0]      w_hdr;
  logic                   w_hdr_read;
  logic [c_IDX_W-1:0]     w_hdr_idx;
  logic                   w_hdr_ok;
  logic [DATA_W-1:0]      w_rd_val;
  logic [DATA_W-1:0]      r_miso_sr;
  logic                   r_miso_oeb;

  assign w_sclk_fall = ~w_sclk_s & r_sclk_prev;
  assign w_hdr       = r_shift[ADDR_W-1:0];
  assign w_hdr_read  = w_hdr[ADDR_W-1];
  assign w_hdr_idx   = w_hdr[c_IDX_W-1:0];
  assign w_hdr_ok    = ({1'b0, w_hdr_idx} < c_NUM);
  assign w_rd_val    = w_hdr_ok ? r_regs[int'(w_hdr_idx)*DATA_W +: DATA_W] : '0;

  // Once the command is in, the addressed value is loaded on the falling
  // edge and shifted MSB-first; the drive stops after the last data bit.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_miso_sr  <= '0;
      r_miso_oeb <= 1'b1;
    end else if ((r_state != S_SHIFT) || w_csb_s) begin
      r_miso_sr  <= '0;
      r_miso_oeb <= 1'b1;
    end else if (w_sclk_fall) begin
      if ((r_count == c_HDR) && w_hdr_read) begin
        r_miso_sr  <= w_rd_val;
        r_miso_oeb <= 1'b0;
      end else if (!r_miso_oeb) begin
        if (r_count == c_LEN) begin
          r_miso_sr  <= '0;
          r_miso_oeb <= 1'b1;
        end else begin
          r_miso_sr <= r_miso_sr << 1;
        end
      end
    end
  end

  assign o_miso     = r_miso_sr[DATA_W-1];
  assign o_miso_oeb = r_miso_oeb;
`else
  assign o_miso     = 1'b0;
  assign o_miso_oeb = 1'b1;
`endif

  assign o_regs        = r_regs;
  assign o_pending     = r_pending;
  assign o_commit_done = r_commit_done;
  assign o_err         = r_err;
  assign o_busy        = ~w_csb_s && (r_state != S_WAIT_HIGH);

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_bank.sv
// ============================================================================
// Module   : tb_spi_reg_bank
// Brief    : Directed, table-driven bench for spi_reg_bank.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_reg_bank;

  localparam int NR = 8;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam logic [NR*DW-1:0] c_RST = {16'h7007, 16'h6006, 16'h5005, 16'h4004,
                                        16'h3003, 16'h2002, 16'h1001, 16'h0000};

  logic i_clk, i_reset, i_sclk, i_csb, i_mosi, i_commit;
  logic [NR*DW-1:0] o_regs;
  logic o_pending, o_commit_done, o_err, o_busy, o_miso, o_miso_oeb;

  spi_reg_bank #(
    .NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW), .SYNC_STAGES(2), .RESET_VALUES(c_RST)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_sclk(i_sclk), .i_csb(i_csb),
    .i_mosi(i_mosi), .i_commit(i_commit), .o_regs(o_regs), .o_pending(o_pending),
    .o_commit_done(o_commit_done), .o_err(o_err), .o_busy(o_busy),
    .o_miso(o_miso), .o_miso_oeb(o_miso_oeb)
  );

  typedef struct {
    logic [31:0] bits;
    int          nbits;
    int          exp_err;
    logic        exp_pend;
  } vec_t;

  vec_t        vecs [5];
  logic [DW-1:0] exp_regs [NR];
  logic [DW-1:0] rx;
  int n_pass, n_total, err_total, done_total, oeb_lo, e0, d0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_err) err_total++;
    if (o_commit_done) done_total++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  function automatic logic [NR*DW-1:0] model_flat();
    logic [NR*DW-1:0] f;
    for (int k = 0; k < NR; k++) f[k*DW +: DW] = exp_regs[k];
    return f;
  endfunction

  task automatic reset_model();
    for (int k = 0; k < NR; k++) exp_regs[k] = 16'(k * 32'h1001);
  endtask

  task automatic commit_pulse();
    i_commit = 1'b1;
    @(negedge i_clk);
    i_commit = 1'b0;
  endtask

  // Mode-0 master: 4 clk per half sclk. rst_at pulses i_reset before that
  // bit index; cae raises i_commit in the cycle the DUT sees csb rise.
  task automatic spi_frame(input logic [31:0] bits, input int n, input int rst_at, input bit cae);
    i_csb = 1'b0;
    repeat (4) @(negedge i_clk);
    for (int i = n - 1; i >= 0; i--) begin
      if ((n - 1 - i) == rst_at) begin
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
      end
      i_mosi = bits[i];
      repeat (4) @(negedge i_clk);
      if (i < DW) begin
        rx = {rx[DW-2:0], o_miso};
        if (!o_miso_oeb) oeb_lo++;
      end
      i_sclk = 1'b1;
      repeat (4) @(negedge i_clk);
      i_sclk = 1'b0;
    end
    repeat (4) @(negedge i_clk);
    i_csb = 1'b1;
    if (cae) begin
      repeat (2) @(negedge i_clk);
      commit_pulse();
    end
    repeat (8) @(negedge i_clk);
    i_mosi = 1'b0;
  endtask

  initial begin
    n_pass = 0; n_total = 0; err_total = 0; done_total = 0; oeb_lo = 0; rx = '0;
    i_reset = 1'b1; i_sclk = 1'b0; i_csb = 1'b1; i_mosi = 1'b0; i_commit = 1'b0;
    reset_model();

    vecs[0] = '{32'h0001_BEEF, 19, 1, 1'b0};
    vecs[1] = '{32'h0015_BEEF, 21, 1, 1'b0};
`ifdef SPI_REG_READBACK_EN
    vecs[2] = '{32'h0009_CAFE, 20, 0, 1'b0};
`else
    vecs[2] = '{32'h0009_CAFE, 20, 1, 1'b0};
`endif
    vecs[3] = '{32'h0000_0000, 0, 0, 1'b0};
    vecs[4] = '{32'h0003_BEEF, 20, 0, 1'b1};

    repeat (5) @(negedge i_clk);
    chk("rst_regs", o_regs, model_flat());
    chk("rst_pending", o_pending, 0);
    chk("rst_err", o_err, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_miso", o_miso, 0);
    chk("rst_oeb", o_miso_oeb, 1);
    chk("rst_done", o_commit_done, 0);
    i_reset = 1'b0;
    repeat (6) @(negedge i_clk);

    i_csb = 1'b0;
    repeat (4) @(negedge i_clk);
    chk("busy_low_csb", o_busy, 1);
    i_csb = 1'b1;
    repeat (4) @(negedge i_clk);
    chk("busy_high_csb", o_busy, 0);

    for (int v = 0; v < 5; v++) begin
      e0 = err_total;
      spi_frame(vecs[v].bits, vecs[v].nbits, -1, 1'b0);
      chk($sformatf("vec%0d_err", v), err_total - e0, vecs[v].exp_err);
      chk($sformatf("vec%0d_pending", v), o_pending, vecs[v].exp_pend);
      chk($sformatf("vec%0d_regs", v), o_regs, model_flat());
    end
`ifndef SPI_REG_READBACK_EN
    chk("no_readback_oeb", oeb_lo, 0);
`endif

    commit_pulse();
    exp_regs[3] = 16'hBEEF;
    chk("commit_done", o_commit_done, 1);
    chk("commit_pending", o_pending, 0);
    chk("commit_regs", o_regs, model_flat());
    @(negedge i_clk);
    chk("commit_done_1cyc", o_commit_done, 0);

    d0 = done_total;
    commit_pulse();
    repeat (2) @(negedge i_clk);
    chk("idle_commit_done", done_total - d0, 0);
    chk("idle_commit_regs", o_regs, model_flat());

    spi_frame({12'h0, 4'd1, 16'h1111}, 20, -1, 1'b0);
    spi_frame({12'h0, 4'd1, 16'h2222}, 20, -1, 1'b0);
    commit_pulse();
    exp_regs[1] = 16'h2222;
    @(negedge i_clk);
    chk("overwrite_regs", o_regs, model_flat());
    chk("overwrite_pending", o_pending, 0);

    spi_frame({12'h0, 4'd1, 16'h3C3C}, 20, -1, 1'b0);
    d0 = done_total;
    spi_frame({12'h0, 4'd1, 16'h4D4D}, 20, -1, 1'b1);
    exp_regs[1] = 16'h3C3C;
    chk("simul_regs", o_regs, model_flat());
    chk("simul_pending", o_pending, 1);
    chk("simul_done", done_total - d0, 1);
    commit_pulse();
    exp_regs[1] = 16'h4D4D;
    @(negedge i_clk);
    chk("simul_next_regs", o_regs, model_flat());
    chk("simul_next_pending", o_pending, 0);

    e0 = err_total;
    spi_frame({12'h0, 4'd6, 16'h9999}, 20, 10, 1'b0);
    reset_model();
    chk("rstmid_err", err_total - e0, 0);
    chk("rstmid_pending", o_pending, 0);
    chk("rstmid_regs", o_regs, model_flat());
    e0 = err_total;
    spi_frame({12'h0, 4'd5, 16'h1234}, 20, -1, 1'b0);
    chk("clean_err", err_total - e0, 0);
    chk("clean_pending", o_pending, 1);
    commit_pulse();
    exp_regs[5] = 16'h1234;
    @(negedge i_clk);
    chk("clean_regs", o_regs, model_flat());

`ifdef SPI_REG_READBACK_EN
    spi_frame({12'h0, 4'd2, 16'hA5C3}, 20, -1, 1'b0);
    commit_pulse();
    exp_regs[2] = 16'hA5C3;
    @(negedge i_clk);
    rx = '0; oeb_lo = 0; e0 = err_total;
    spi_frame({12'h0, 4'b1010, 16'h0000}, 20, -1, 1'b0);
    chk("rd_data", rx, 16'hA5C3);
    chk("rd_oeb_bits", oeb_lo, 16);
    chk("rd_oeb_after", o_miso_oeb, 1);
    chk("rd_pending", o_pending, 0);
    chk("rd_err", err_total - e0, 0);
    chk("rd_regs", o_regs, model_flat());
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
